rgmii_tx_arbiter: RTL
=====================

RGMII_TX_ARBITER -- requirements
Module: rgmii_tx_arbiter

Interface
REQ-001 Parameter: IFG_CYCLES, 12, idle cycles inserted after each frame when gap insertion is compiled in; legal range 1..255.
REQ-002 Port: clk_int  input  1  single 125 MHz clock; all state on rising edge.
REQ-003 Port: rst_int  input  1  reset, asynchronous, active-high.
REQ-004 Port: s0_axis_tdata/tvalid/tlast/tuser  input  8/1/1/1  requester 0 byte stream (CPU frame path).
REQ-005 Port: s0_axis_tready  output  1  requester 0 accept.
REQ-006 Port: s1_axis_tdata/tvalid/tlast/tuser  input  8/1/1/1  requester 1 byte stream (control/pause frame path).
REQ-007 Port: s1_axis_tready  output  1  requester 1 accept.
REQ-008 Port: m_axis_tdata/tvalid/tlast/tuser  output  8/1/1/1  merged stream to the MAC tx_axis input.
REQ-009 Port: m_axis_tready  input  1  MAC accept.
REQ-010 Port: grant  output  2  one-hot current owner; 2'b00 when no owner.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: frame_cnt0, frame_cnt1  output  16 each  frames completed per requester.

Function
REQ-013 FSM states: IDLE, XFER, GAP (GAP only exists with the macro compiled in).
REQ-014 IDLE: m_axis_tvalid=0, both s*_tready=0, grant=00; if any s*_tvalid=1, register a grant and move to XFER on the next edge (one arbitration cycle per frame).
REQ-015 Round-robin: both requesting -> grant the port not granted last; single requester -> that port; last_grant resets to port 1, so port 0 wins the first contention.
REQ-016 XFER: m_axis_tdata/tvalid/tlast/tuser = granted port's inputs combinationally; granted s*_tready = m_axis_tready; ungranted tready = 0; zero added latency per beat.
REQ-017 XFER outputs m_axis_tdata=0, tlast=0, tuser=0 whenever tvalid=0; in IDLE/GAP all m_axis data outputs are 0.
REQ-018 Grant is locked for the whole frame; granted tvalid dropping mid-frame does not release it and the other port stays stalled.
REQ-019 Frame end = beat with granted tvalid & m_axis_tready & tlast; next state GAP (macro on) or IDLE (macro off); last_grant updated to that port.
REQ-020 frame_cnt of the granted port increments by 1 on frame end, wraps 16'hFFFF -> 0; tuser=1 on the last beat still counts.
REQ-021 A new tvalid arriving on the same cycle as frame end is not served until after the mandatory IDLE cycle (and GAP, if on).
REQ-022 Single-beat frame (tvalid & tlast on first beat) is legal and completes XFER in one cycle.

Reset
REQ-023 rst_int asserted: immediately state=IDLE, last_grant=1, gap counter=0, frame_cnt0/1=0, grant=00, busy=0, all tready/m_axis outputs 0, without waiting for clk_int.
REQ-024 Reset mid-frame truncates the frame with no tlast emitted; the counter of the truncated frame is not incremented; after release, arbitration restarts from IDLE.

Configuration
REQ-025 Macro RGMII_TX_ARB_IFG_EN defined: after frame end, state GAP holds for exactly IFG_CYCLES cycles with all tready=0, m_axis_tvalid=0, busy=1, then IDLE.
REQ-026 Macro RGMII_TX_ARB_IFG_EN undefined: no GAP state or counter; frame end returns to IDLE directly; IFG_CYCLES is ignored.

Verification
REQ-027 Only s0 sends a 64-byte frame, m_axis_tready=1 -> grant=01 one cycle after tvalid, 64 bytes out unchanged, frame_cnt0=1, tlast on byte 64.
REQ-028 s0 and s1 both valid from reset with 3 frames each -> output order s0,s1,s0,s1,s0,s1; frame_cnt0=frame_cnt1=3.
REQ-029 s1 frame with m_axis_tready toggling 1/0 and s1 tvalid gap of 5 cycles mid-frame, s0 requesting -> s0_axis_tready stays 0 until s1 tlast accepted; no byte lost or duplicated.
REQ-030 Macro on, IFG_CYCLES=12, back-to-back s0 frames -> exactly 12 GAP cycles plus 1 IDLE cycle between last beat and next first beat; macro off -> exactly 1 IDLE cycle.
REQ-031 rst_int pulsed at byte 20 of a 40-byte s1 frame -> all outputs 0 asynchronously, frame_cnt1=0; following s0 frame granted first and completes normally.
REQ-032 frame_cnt0 preloaded by 65535 single-beat s0 frames, one more -> frame_cnt0 wraps to 0.

Source files
------------

// File: rtl/rgmii_tx_arbiter.sv
// Round-robin, frame-locked merge of two byte streams onto one MAC tx stream.
// Define RGMII_TX_ARB_IFG_EN to insert IFG_CYCLES idle cycles after every frame.
module rgmii_tx_arbiter #(
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk_int,
  input  logic        rst_int,
  input  logic [7:0]  s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,
  output logic        s0_axis_tready,
  input  logic [7:0]  s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,
  output logic        s1_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1
);

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_ifg_range
    $error("rgmii_tx_arbiter: IFG_CYCLES must be within 1..255");
  end

`ifdef RGMII_TX_ARB_IFG_EN
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  logic [7:0] gap_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q;
  logic [15:0] cnt0_q, cnt1_q;
  logic        sel_valid, sel_last, sel_user, frame_end;
  logic [7:0]  sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = 8'd0;
    if (grant_q[1]) begin
      sel_valid = s1_axis_tvalid;
      sel_last  = s1_axis_tlast;
      sel_user  = s1_axis_tuser;
      sel_data  = s1_axis_tdata;
    end else if (grant_q[0]) begin
      sel_valid = s0_axis_tvalid;
      sel_last  = s0_axis_tlast;
      sel_user  = s0_axis_tuser;
      sel_data  = s0_axis_tdata;
    end
  end

  assign frame_end = (state_q == XFER) && sel_valid && m_axis_tready && sel_last;

  // Data outputs are forced to zero on any cycle without a valid beat.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 8'd0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state_q == XFER) begin
      m_axis_tvalid  = sel_valid;
      s0_axis_tready = grant_q[0] & m_axis_tready;
      s1_axis_tready = grant_q[1] & m_axis_tready;
      if (sel_valid) begin
        m_axis_tdata = sel_data;
        m_axis_tlast = sel_last;
        m_axis_tuser = sel_user;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d = XFER;
          if (s0_axis_tvalid && s1_axis_tvalid)
            grant_d = last_grant_q ? 2'b01 : 2'b10;
          else if (s0_axis_tvalid)
            grant_d = 2'b01;
          else
            grant_d = 2'b10;
        end
      end
      XFER: begin
        if (frame_end) begin
          grant_d = 2'b00;
`ifdef RGMII_TX_ARB_IFG_EN
          state_d = GAP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef RGMII_TX_ARB_IFG_EN
      GAP: begin
        if (gap_cnt_q <= 8'd1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      cnt0_q       <= 16'd0;
      cnt1_q       <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (frame_end) begin
        last_grant_q <= grant_q[1];
        if (grant_q[0]) cnt0_q <= cnt0_q + 16'd1;
        if (grant_q[1]) cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

`ifdef RGMII_TX_ARB_IFG_EN
  // Loaded at frame end; the GAP state exits on the cycle the count reads 1.
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int)
      gap_cnt_q <= 8'd0;
    else if (frame_end)
      gap_cnt_q <= 8'(IFG_CYCLES);
    else if (state_q == GAP && gap_cnt_q != 8'd0)
      gap_cnt_q <= gap_cnt_q - 8'd1;
  end
`endif

  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;

endmodule
